// File: rtl/logic_proc_pkg.sv
// rtl/logic_proc_pkg.sv - shared types and sizing helpers for the logic processor controller
package logic_proc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } ctrl_state_t;

  localparam int REG_WIDTH = 8;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_counter.sv
// rtl/shift_counter.sv - loadable up-counter with clear, enable and terminal count at WIDTH-1
module shift_counter
  import logic_proc_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH,
  localparam int CW = cnt_w(WIDTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_tc
);

  logic [CW-1:0] r_count;

  // Saturates at WIDTH so the count can never run past the register width.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != CW'(WIDTH))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_control_unit.sv
// rtl/shift_control_unit.sv - load/shift sequencer for the A/B shift-register pair; SHIFT_CTRL_STEP_EN adds single-step input
module shift_control_unit
  import logic_proc_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      LoadA,
  input  logic                      LoadB,
  input  logic                      Execute,
`ifdef SHIFT_CTRL_STEP_EN
  input  logic                      Step,
`endif
  output logic                      Ld_A,
  output logic                      Ld_B,
  output logic                      Shift_En,
  output logic                      Busy,
  output logic                      Done,
  output logic [cnt_w(WIDTH)-1:0]   Shift_Cnt
);

  localparam int CW = cnt_w(WIDTH);

  ctrl_state_t   r_state;
  logic          w_step;
  logic          w_adv;
  logic          w_clr;
  logic          w_tc;
  logic          w_idle;
  logic [CW-1:0] w_cnt;

`ifdef SHIFT_CTRL_STEP_EN
  assign w_step = Step;
`else
  assign w_step = 1'b1;
`endif

  assign w_idle = (r_state == IDLE);
  assign w_clr  = w_idle & Execute;
  assign w_adv  = (r_state == SHIFT) & w_step;

  shift_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .i_clk      (Clk),
    .i_rst_n    (Reset),
    .i_clr      (w_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_adv),
    .o_count    (w_cnt),
    .o_tc       (w_tc)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (Execute)        r_state <= SHIFT;
        SHIFT:   if (w_adv && w_tc)  r_state <= HOLD;
        HOLD:    if (!Execute)       r_state <= IDLE;
        default:                     r_state <= IDLE;
      endcase
    end
  end

  // Loads are gated by Reset so no strobe escapes while the unit is held in reset.
  assign Ld_A      = w_idle & Reset & LoadA & ~Execute;
  assign Ld_B      = w_idle & Reset & LoadB & ~Execute;
  assign Shift_En  = w_adv;
  assign Busy      = ~w_idle;
  assign Done      = (r_state == HOLD);
  assign Shift_Cnt = w_cnt;

endmodule

// File: tb/tb_shift_control_unit.sv
// tb/tb_shift_control_unit.sv - self-checking bench for shift_control_unit
module tb_shift_control_unit;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          LoadA = 1'b0;
  logic          LoadB = 1'b0;
  logic          Execute = 1'b0;
`ifdef SHIFT_CTRL_STEP_EN
  logic          Step = 1'b1;
`endif
  logic          Ld_A, Ld_B, Shift_En, Busy, Done;
  logic [CW-1:0] Shift_Cnt;

  shift_control_unit #(.WIDTH(WIDTH)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .LoadA     (LoadA),
    .LoadB     (LoadB),
    .Execute   (Execute),
`ifdef SHIFT_CTRL_STEP_EN
    .Step      (Step),
`endif
    .Ld_A      (Ld_A),
    .Ld_B      (Ld_B),
    .Shift_En  (Shift_En),
    .Busy      (Busy),
    .Done      (Done),
    .Shift_Cnt (Shift_Cnt)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an operation is "running" for WIDTH shift slots, then "holding" until Execute drops.
  int m_cnt  = 0;
  bit m_run  = 1'b0;
  bit m_hold = 1'b0;

  function automatic bit step_ok();
`ifdef SHIFT_CTRL_STEP_EN
    return Step;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_cnt = 0; m_run = 1'b0; m_hold = 1'b0;
    end else if (m_run) begin
      if (step_ok()) begin
        m_cnt++;
        if (m_cnt == WIDTH) begin m_run = 1'b0; m_hold = 1'b1; end
      end
    end else if (m_hold) begin
      if (!Execute) m_hold = 1'b0;
    end else if (Execute) begin
      m_run = 1'b1; m_cnt = 0;
    end
  end

  always @(negedge Clk) begin
    bit idle;
    idle = !m_run && !m_hold;
    chk("cyc_ld_a",     Ld_A,      int'(Reset && idle && LoadA && !Execute));
    chk("cyc_ld_b",     Ld_B,      int'(Reset && idle && LoadB && !Execute));
    chk("cyc_shift_en", Shift_En,  int'(m_run && step_ok()));
    chk("cyc_busy",     Busy,      int'(!idle));
    chk("cyc_done",     Done,      int'(m_hold));
    chk("cyc_cnt",      Shift_Cnt, m_cnt);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  int pulses, first, last, holds, ldb_busy;

  initial begin
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_shift_en", Shift_En, 0);
    chk("rst_cnt", Shift_Cnt, 0);
    tick(); Reset = 1'b1;

    tick(); LoadA = 1'b1;
    @(negedge Clk);
    chk("loada_ld_a", Ld_A, 1);
    chk("loada_ld_b", Ld_B, 0);
    chk("loada_busy", Busy, 0);
    chk("loada_cnt", Shift_Cnt, 0);
    tick(); LoadA = 1'b0; LoadB = 1'b1;
    @(negedge Clk);
    chk("loadb_ld_b", Ld_B, 1);
    chk("loadb_ld_a", Ld_A, 0);

    // Execute wins over simultaneous loads, then is held for 20 cycles.
    tick(); LoadA = 1'b1; LoadB = 1'b1; Execute = 1'b1;
    @(negedge Clk);
    chk("prio_ld_a", Ld_A, 0);
    chk("prio_ld_b", Ld_B, 0);
    pulses = 0; first = -1; last = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      @(negedge Clk);
      if (i == 1) chk("first_pulse", Shift_En, 1);
      if (Shift_En) begin
        pulses++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("held_pulses", pulses, 8);
    chk("held_first", first, 1);
    chk("held_last", last, 8);
    chk("held_done", Done, 1);
    chk("held_busy", Busy, 1);
    chk("held_cnt", Shift_Cnt, 8);
    tick(); Execute = 1'b0; LoadA = 1'b0; LoadB = 1'b0;
    @(negedge Clk);
    chk("release_still_done", Done, 1);
    tick();
    @(negedge Clk);
    chk("release_done", Done, 0);
    chk("release_busy", Busy, 0);
    chk("release_cnt", Shift_Cnt, 8);

    // Single-cycle Execute with LoadB asserted throughout the operation.
    tick(); Execute = 1'b1;
    @(negedge Clk);
    pulses = 0; holds = 0; ldb_busy = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 1) begin Execute = 1'b0; LoadB = 1'b1; end
      @(negedge Clk);
      if (Shift_En) pulses++;
      if (Done) holds++;
      if (Busy && Ld_B) ldb_busy++;
    end
    chk("pulse_pulses", pulses, 8);
    chk("pulse_holds", holds, 1);
    chk("pulse_ldb_busy", ldb_busy, 0);
    chk("pulse_idle_ld_b", Ld_B, 1);
    tick(); LoadB = 1'b0;

    // Asynchronous reset after three shifts.
    tick(); Execute = 1'b1;
    @(negedge Clk);
    for (int i = 1; i <= 3; i++) begin
      tick();
      @(negedge Clk);
    end
    tick();
    chk("pre_rst_cnt", Shift_Cnt, 3);
    #2 Reset = 1'b0;
    #1;
    chk("arst_shift_en", Shift_En, 0);
    chk("arst_busy", Busy, 0);
    chk("arst_done", Done, 0);
    chk("arst_cnt", Shift_Cnt, 0);
    @(negedge Clk);
    tick(); Reset = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      @(negedge Clk);
      if (Shift_En) pulses++;
    end
    chk("rerun_pulses", pulses, 8);
    chk("rerun_cnt", Shift_Cnt, 8);
    tick(); Execute = 1'b0;
    tick();
    tick();

`ifdef SHIFT_CTRL_STEP_EN
    Step = 1'b0;
    tick(); Execute = 1'b1;
    @(negedge Clk);
    pulses = 0;
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        @(negedge Clk);
        if (Shift_En) pulses++;
      end
      tick(); Step = 1'b1;
      @(negedge Clk);
      chk("step_shift_en", Shift_En, 1);
      tick(); Step = 1'b0;
      @(negedge Clk);
      if (s < 7) chk("step_between_en", Shift_En, 0);
    end
    chk("step_gap_pulses", pulses, 0);
    chk("step_done", Done, 1);
    chk("step_cnt", Shift_Cnt, 8);
    tick(); Execute = 1'b0;
    tick();
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_control_unit.md
Name: shift_control_unit

Overview:
- Sequencing controller for the logic processor's two 8-bit shift-register datapath (register pair A/B with Ld_A, Ld_B, Shift_En).
- Turns the operator controls (LoadA, LoadB, Execute) into cycle-exact load and shift strobes.
- Runs exactly WIDTH shifts per Execute press, then holds until Execute is released.
- Sits between the switch/button synchronisers and the register unit.

Parameters:
- WIDTH, 8, number of shift cycles per operation; equals the register width; legal range 2..32.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- LoadA  input  1  request to load register A from the data switches (synchronised, level).
- LoadB  input  1  request to load register B from the data switches (synchronised, level).
- Execute  input  1  start request (synchronised, level).
- Ld_A  output  1  load strobe to register A.
- Ld_B  output  1  load strobe to register B.
- Shift_En  output  1  shift strobe to both registers.
- Busy  output  1  high in any state other than IDLE.
- Done  output  1  high in HOLD: the operation is complete and Execute is still held.
- Shift_Cnt  output  $clog2(WIDTH+1)  number of shifts done in the current operation.

Behaviour:
- Reset low (asynchronous): state=IDLE, Shift_Cnt=0, and Ld_A, Ld_B, Shift_En, Busy, Done all 0. Release is synchronous to Clk.
- States: IDLE, SHIFT, HOLD (enum in package).
- IDLE outputs:
  - Ld_A = LoadA & ~Execute and Ld_B = LoadB & ~Execute. These are combinational, zero latency, and may be asserted on the same cycle.
  - Shift_En=0.
- IDLE transition: Execute=1 moves to SHIFT on the next edge and clears Shift_Cnt to 0. Execute takes priority over LoadA/LoadB in the same cycle: no load happens.
- SHIFT:
  - Shift_En=1 every cycle. Ld_A=Ld_B=0 whatever LoadA/LoadB do.
  - Shift_Cnt increments by 1 each cycle.
  - On the cycle where Shift_Cnt==WIDTH-1, move to HOLD. Shift_Cnt reads WIDTH in HOLD.
  - Exactly WIDTH Shift_En pulses per operation, on consecutive cycles.
  - The first pulse comes on the cycle after Execute is sampled high (1-cycle latency).
- Execute released during SHIFT: no abort. The sequence completes, and HOLD exits on the first cycle it sees Execute=0.
- HOLD:
  - Done=1, Shift_En=0, Ld_A=Ld_B=0.
  - Shift_Cnt holds WIDTH.
  - Execute=0 moves to IDLE on the next edge. Shift_Cnt stays WIDTH until the next operation starts.
- A held Execute gives exactly one operation; a new operation needs Execute to go 0 and then 1 again.
- Reset asserted mid-SHIFT: immediate IDLE, and Shift_En drops asynchronously. The datapath keeps its partially shifted contents.
- Output decode: Busy = (state!=IDLE), Done = (state==HOLD). Both come from registered state, so they are glitch-free.
- Shift_Cnt must never exceed WIDTH.

Optional Feature:
- Macro: SHIFT_CTRL_STEP_EN.
- When defined:
  - Adds input Step (1 bit, synchronised, single-cycle pulse).
  - In SHIFT, Shift_En = Step and Shift_Cnt increments only on Step cycles. Exit to HOLD happens on the Step cycle where Shift_Cnt==WIDTH-1.
  - The FSM waits in SHIFT indefinitely between steps.
  - Step is ignored in IDLE and HOLD.
- When not defined: the Step port does not exist, and SHIFT shifts every cycle as described above.

Decomposition:
- Package logic_proc_pkg holds:
  - typedef enum logic [1:0] ctrl_state_t {IDLE, SHIFT, HOLD};
  - localparam REG_WIDTH = 8 (the default source for WIDTH);
  - function cnt_w(WIDTH) returning $clog2(WIDTH+1).
- One natural sub-module: shift_counter. It is a loadable up-counter with clear, enable and terminal-count output (tc when count==WIDTH-1). It uses the same asynchronous active-low Reset.
- The FSM and the output decode stay in shift_control_unit.

Test Plan:
- Reset low mid-idle, then LoadA=1 and Execute=0 for 1 cycle → Ld_A=1 on that cycle, Ld_B=0, Busy=0, Shift_Cnt=0.
- LoadA=1, LoadB=1 and Execute=1 on the same cycle in IDLE → Ld_A=Ld_B=0. Next edge: SHIFT, Shift_En=1.
- Execute held for 20 cycles with WIDTH=8 → exactly 8 consecutive Shift_En pulses, Shift_Cnt 0→8, then Done=1 and Busy=1 until Execute=0. One cycle after release: IDLE, Done=0.
- Execute pulsed for 1 cycle → 8 Shift_En pulses, then HOLD for exactly 1 cycle, then IDLE. LoadB=1 during SHIFT → Ld_B stays 0.
- Reset driven low after 3 shifts → Shift_En, Busy and Done go to 0 immediately, Shift_Cnt=0. After release with Execute=1 → a fresh 8-shift run.
- SHIFT_CTRL_STEP_EN defined, Execute=1, 8 Step pulses spaced 5 cycles apart → Shift_En coincides only with the Step cycles. HOLD is entered after the 8th Step, and Shift_Cnt=8.
